bster_cmd_ingress: RTL and testbench
====================================

// Module: bster_cmd_ingress
// PURPOSE
//  Upstream front-end of the bster core's command port. Accepts host commands as a narrow
//  AXI-stream (IN_WIDTH beats framed by tlast) and assembles them into CMD_WIDTH words.
//  Checks framing and opcode, buffers good commands in a FIFO that drives bster cmd_tvalid/
//  cmd_tready/cmd_tdata, and reports rejected commands on a small error stream.
// PARAMETERS
//  IN_WIDTH    32   host stream data width; CMD_WIDTH % IN_WIDTH == 0
//  CMD_WIDTH   128  assembled command width (matches bster CMD_WIDTH)
//  FIFO_DEPTH  8    command FIFO entries, power of two, >= 2
//  CNT_WIDTH   16   width of accepted/dropped counters
// PORTS
//  aclk           in   1          clock
//  aresetn        in   1          synchronous reset, active low
//  s_tvalid       in   1          host beat valid
//  s_tready       out  1          host beat ready
//  s_tdata        in   IN_WIDTH   host beat data
//  s_tlast        in   1          last beat of a command
//  cmd_tvalid     out  1          command valid to bster
//  cmd_tready     in   1          bster accepts command
//  cmd_tdata      out  CMD_WIDTH  assembled command
//  err_tvalid     out  1          error report valid
//  err_tready     in   1          error report accepted
//  err_tdata      out  8          [7]=overflow, [6:2]=0, [1:0]=code
//  cmd_cnt        out  CNT_WIDTH  commands pushed to FIFO, wraps
//  drop_cnt       out  CNT_WIDTH  commands rejected, wraps
// BEHAVIOUR
//  - Reset (aresetn low at posedge): all outputs 0, incl. s_tready; FIFO emptied, beat idx 0,
//    state COLLECT, error slot empty. Reset mid-packet drops partial command, no error.
//  - BEATS = CMD_WIDTH/IN_WIDTH. Beat k fills cmd[k*IN_WIDTH +: IN_WIDTH] (beat 0 = LSBs).
//  - Opcode = cmd[7:0]; legal 0x01 INSERT, 0x02 SEARCH, 0x03 DELETE.
//  - s_tready = (state==DISCARD) | !fifo_full. Transfer = s_tvalid & s_tready.
//  - FSM COLLECT: each transfer stores beat, idx++.
//     tlast & idx<BEATS-1            -> drop, error 2'b01 (short), idx=0, stay COLLECT.
//     idx==BEATS-1 & tlast           -> opcode legal: push FIFO, cmd_cnt++;
//                                       else error 2'b11 (opcode); idx=0.
//     idx==BEATS-1 & !tlast          -> error 2'b10 (long), go DISCARD.
//  - DISCARD: accept and drop beats; transfer with tlast -> COLLECT, idx=0.
//  - Each error increments drop_cnt once per command (long packet counted once).
//  - Latency: last-beat transfer at edge N -> cmd_tvalid high after edge N (next cycle),
//    when FIFO was empty. cmd_tdata stable while cmd_tvalid & !cmd_tready.
//  - FIFO full: s_tready low in COLLECT; no beat lost, no overwrite. Push & pop same cycle
//    when full is not possible (ready already low); push & pop when not full: count unchanged.
//  - Error slot: single register. New error with slot empty or popping same cycle -> load
//    code, overflow=0. New error with slot held -> keep code, set bit7 (lost error).
//    err_tvalid held until err_tready; errors never stall s_tready.
//  - Counters wrap 2^CNT_WIDTH-1 -> 0.
// STRUCTURE
//  - bster_pkg: opcode constants (OP_INSERT/SEARCH/DELETE), error codes
//    (ERR_SHORT/LONG/OPCODE), FSM state enum {COLLECT, DISCARD}.
//  - Sub-module bster_sync_fifo (WIDTH, DEPTH): registered-output sync FIFO, full/empty,
//    valid/ready on read side; reusable for bster cpl/sts paths.
//  - Top holds assembly shift register, beat counter, FSM, error slot, counters.
// TESTING
//  1 Four beats 0x01,0x11111111,0x22222222,0x33333333(tlast), cmd_tready=1 ->
//    cmd_tdata=0x33333333_22222222_11111111_00000001 next cycle, cmd_cnt=1.
//  2 Two beats, tlast on beat 2 -> no cmd_tvalid, err_tdata=0x01, drop_cnt=1.
//  3 Six beats, tlast on beat 6, then good command -> err 0x02 once, drop_cnt=1,
//    following command delivered intact.
//  4 Opcode 0x07 framed correctly -> err 0x03, no FIFO push; err_tready=0 and opcode 0x00
//    next -> err_tdata=0x83.
//  5 cmd_tready=0, send 9 good commands -> 8 queued, s_tready low on 9th; release ready ->
//    9 commands out in order, cmd_cnt=9.
//  6 aresetn low after beat 2 of a command -> outputs 0; next full command delivered alone.

Source files
------------

// File: rtl/bster_pkg.sv
// rtl/bster_pkg.sv - shared opcode, error-code and ingress state definitions for the bster core
package bster_pkg;

    localparam logic [7:0] OP_INSERT = 8'h01;
    localparam logic [7:0] OP_SEARCH = 8'h02;
    localparam logic [7:0] OP_DELETE = 8'h03;

    localparam logic [1:0] ERR_SHORT  = 2'b01;
    localparam logic [1:0] ERR_LONG   = 2'b10;
    localparam logic [1:0] ERR_OPCODE = 2'b11;

    typedef enum logic {
        COLLECT = 1'b0,
        DISCARD = 1'b1
    } ingress_state_e;

    function automatic logic op_legal(input logic [7:0] op);
        return (op == OP_INSERT) || (op == OP_SEARCH) || (op == OP_DELETE);
    endfunction

endpackage

// File: rtl/bster_sync_fifo.sv
// rtl/bster_sync_fifo.sv - synchronous FIFO with write-side full and read-side valid/ready
module bster_sync_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_wvalid,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_full,
    output logic             o_rvalid,
    input  logic             i_rready,
    output logic [WIDTH-1:0] o_rdata
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full   = (r_count == (AW+1)'(DEPTH));
    assign o_rvalid = (r_count != '0);
    // Data forced to zero while empty so the read port never shows stale entries
    assign o_rdata  = o_rvalid ? r_mem[r_rptr] : '0;
    assign w_push   = i_wvalid & ~o_full;
    assign w_pop    = i_rready & o_rvalid;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

endmodule

// File: rtl/bster_cmd_ingress.sv
// rtl/bster_cmd_ingress.sv - host command assembly, framing/opcode check and command queue
module bster_cmd_ingress
    import bster_pkg::*;
#(
    parameter int IN_WIDTH   = 32,
    parameter int CMD_WIDTH  = 128,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    input  logic [IN_WIDTH-1:0]  s_tdata,
    input  logic                 s_tlast,
    output logic                 cmd_tvalid,
    input  logic                 cmd_tready,
    output logic [CMD_WIDTH-1:0] cmd_tdata,
    output logic                 err_tvalid,
    input  logic                 err_tready,
    output logic [7:0]           err_tdata,
    output logic [CNT_WIDTH-1:0] cmd_cnt,
    output logic [CNT_WIDTH-1:0] drop_cnt
);

    localparam int BEATS = CMD_WIDTH / IN_WIDTH;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    ingress_state_e       r_state;
    ingress_state_e       w_state_nxt;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic [CMD_WIDTH-1:0] r_cmd;
    logic [CMD_WIDTH-1:0] w_asm;
    logic                 r_run;
    logic                 w_xfer;
    logic                 w_push;
    logic                 w_err;
    logic [1:0]           w_err_code;
    logic                 w_fifo_full;
    logic                 w_err_pop;
    logic                 r_err_valid;
    logic [7:0]           r_err_data;
    logic [CNT_WIDTH-1:0] r_cmd_cnt;
    logic [CNT_WIDTH-1:0] r_drop_cnt;

    // r_run keeps s_tready low during and on the cycle right after reset
    assign s_tready   = r_run & ((r_state == DISCARD) | ~w_fifo_full);
    assign w_xfer     = s_tvalid & s_tready;
    assign w_err_pop  = r_err_valid & err_tready;
    assign err_tvalid = r_err_valid;
    assign err_tdata  = r_err_data;
    assign cmd_cnt    = r_cmd_cnt;
    assign drop_cnt   = r_drop_cnt;

    // Command as it looks once the current beat lands, so the last beat pushes directly
    always_comb begin
        w_asm = r_cmd;
        w_asm[r_idx*IN_WIDTH +: IN_WIDTH] = s_tdata;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_push      = 1'b0;
        w_err       = 1'b0;
        w_err_code  = 2'b00;
        if (w_xfer) begin
            if (r_state == COLLECT) begin
                if (r_idx == LAST_IDX) begin
                    w_idx_nxt = '0;
                    if (s_tlast) begin
                        if (op_legal(w_asm[7:0])) begin
                            w_push = 1'b1;
                        end else begin
                            w_err      = 1'b1;
                            w_err_code = ERR_OPCODE;
                        end
                    end else begin
                        w_err       = 1'b1;
                        w_err_code  = ERR_LONG;
                        w_state_nxt = DISCARD;
                    end
                end else if (s_tlast) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_SHORT;
                    w_idx_nxt  = '0;
                end else begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                end
            end else begin
                w_idx_nxt = '0;
                if (s_tlast) begin
                    w_state_nxt = COLLECT;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= COLLECT;
            r_idx   <= '0;
            r_cmd   <= '0;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_run   <= 1'b1;
            if (w_xfer && r_state == COLLECT) begin
                r_cmd <= w_asm;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_err_valid <= 1'b0;
            r_err_data  <= '0;
            r_cmd_cnt   <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_err) begin
                if (!r_err_valid || w_err_pop) begin
                    r_err_valid <= 1'b1;
                    r_err_data  <= {6'b000000, w_err_code};
                end else begin
                    r_err_data[7] <= 1'b1;
                end
            end else if (w_err_pop) begin
                r_err_valid <= 1'b0;
                r_err_data  <= '0;
            end
            if (w_push) begin
                r_cmd_cnt <= r_cmd_cnt + CNT_WIDTH'(1);
            end
            if (w_err) begin
                r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
            end
        end
    end

    bster_sync_fifo #(
        .WIDTH (CMD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .i_clk    (aclk),
        .i_resetn (aresetn),
        .i_wvalid (w_push),
        .i_wdata  (w_asm),
        .o_full   (w_fifo_full),
        .o_rvalid (cmd_tvalid),
        .i_rready (cmd_tready),
        .o_rdata  (cmd_tdata)
    );

endmodule

// File: tb/tb_bster_cmd_ingress.sv
// tb/tb_bster_cmd_ingress.sv - directed self-checking bench for bster_cmd_ingress
module tb_bster_cmd_ingress;

    localparam int CNTW = 4;

    logic             aclk = 1'b0;
    logic             aresetn;
    logic             s_tvalid;
    logic             s_tready;
    logic [31:0]      s_tdata;
    logic             s_tlast;
    logic             cmd_tvalid;
    logic             cmd_tready;
    logic [127:0]     cmd_tdata;
    logic             err_tvalid;
    logic             err_tready;
    logic [7:0]       err_tdata;
    logic [CNTW-1:0]  cmd_cnt;
    logic [CNTW-1:0]  drop_cnt;

    int               n_chk  = 0;
    int               n_pass = 0;
    logic [127:0]     got [$];

    bster_cmd_ingress #(
        .IN_WIDTH   (32),
        .CMD_WIDTH  (128),
        .FIFO_DEPTH (8),
        .CNT_WIDTH  (CNTW)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tdata    (s_tdata),
        .s_tlast    (s_tlast),
        .cmd_tvalid (cmd_tvalid),
        .cmd_tready (cmd_tready),
        .cmd_tdata  (cmd_tdata),
        .err_tvalid (err_tvalid),
        .err_tready (err_tready),
        .err_tdata  (err_tdata),
        .cmd_cnt    (cmd_cnt),
        .drop_cnt   (drop_cnt)
    );

    always #5 aclk = ~aclk;

    always @(negedge aclk) begin
        if (aresetn && cmd_tvalid && cmd_tready) begin
            got.push_back(cmd_tdata);
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [127:0] mk(input int i);
        logic [7:0] op;
        op = 8'(i % 3 + 1);
        return {32'(32'hC0 + i), 32'(32'hB0 + i), 32'(32'hA0 + i), 24'(i), op};
    endfunction

    task automatic rst_on();
        aresetn = 1'b0;
        got.delete();
        @(posedge aclk); #1;
    endtask

    task automatic rst_off();
        aresetn = 1'b1;
        @(posedge aclk); #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l);
        int n;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        #1;
        n = 0;
        while (!s_tready && n < 100) begin
            @(posedge aclk); #1;
            n++;
        end
        if (!s_tready) check("beat_timeout", 128'(s_tready), 128'd1);
        @(posedge aclk); #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_cmd(input logic [127:0] c);
        for (int k = 0; k < 4; k++) begin
            send_beat(c[k*32 +: 32], k == 3);
        end
    endtask

    task automatic pop_err();
        err_tready = 1'b1;
        @(posedge aclk); #1;
        err_tready = 1'b0;
    endtask

    task automatic wait_got(input int n);
        int k;
        k = 0;
        while (got.size() < n && k < 100) begin
            @(posedge aclk); #1;
            k++;
        end
        check("got_count", 128'(got.size()), 128'(n));
    endtask

    initial begin
        logic [127:0] c;
        aresetn    = 1'b0;
        s_tvalid   = 1'b0;
        s_tdata    = '0;
        s_tlast    = 1'b0;
        cmd_tready = 1'b0;
        err_tready = 1'b0;

        // reset state
        rst_on();
        check("rst_s_tready", 128'(s_tready), 128'd0);
        check("rst_cmd_tvalid", 128'(cmd_tvalid), 128'd0);
        check("rst_err_tvalid", 128'(err_tvalid), 128'd0);
        check("rst_cmd_cnt", 128'(cmd_cnt), 128'd0);
        check("rst_drop_cnt", 128'(drop_cnt), 128'd0);
        rst_off();

        // 1: good four-beat command
        cmd_tready = 1'b1;
        send_cmd(128'h33333333_22222222_11111111_00000001);
        check("t1_tvalid", 128'(cmd_tvalid), 128'd1);
        check("t1_tdata", cmd_tdata, 128'h33333333_22222222_11111111_00000001);
        check("t1_cmd_cnt", 128'(cmd_cnt), 128'd1);
        check("t1_err_tvalid", 128'(err_tvalid), 128'd0);

        // 2: short command
        rst_on(); rst_off();
        send_beat(32'h00000001, 1'b0);
        send_beat(32'h00000005, 1'b1);
        check("t2_cmd_tvalid", 128'(cmd_tvalid), 128'd0);
        check("t2_err_tvalid", 128'(err_tvalid), 128'd1);
        check("t2_err_tdata", 128'(err_tdata), 128'h01);
        check("t2_drop_cnt", 128'(drop_cnt), 128'd1);
        check("t2_cmd_cnt", 128'(cmd_cnt), 128'd0);
        pop_err();
        check("t2_err_popped", 128'(err_tvalid), 128'd0);

        // 3: long command then a good one
        rst_on(); rst_off();
        for (int k = 0; k < 6; k++) begin
            send_beat((k == 0) ? 32'd1 : 32'(k), k == 5);
        end
        check("t3_err_tdata", 128'(err_tdata), 128'h02);
        check("t3_drop_cnt", 128'(drop_cnt), 128'd1);
        send_cmd(128'h0000CCCC_0000BBBB_AAAA0000_00000003);
        wait_got(1);
        check("t3_cmd", got[0], 128'h0000CCCC_0000BBBB_AAAA0000_00000003);
        check("t3_drop_once", 128'(drop_cnt), 128'd1);
        check("t3_cmd_cnt", 128'(cmd_cnt), 128'd1);
        check("t3_err_held", 128'(err_tdata), 128'h02);

        // 4: illegal opcodes, second one while slot still held
        rst_on(); rst_off();
        send_cmd(128'h00000003_00000002_00000001_00000007);
        check("t4_err_opcode", 128'(err_tdata), 128'h03);
        check("t4_no_push", 128'(cmd_cnt), 128'd0);
        send_cmd(128'h00000009_00000008_00000007_00000000);
        check("t4_err_overflow", 128'(err_tdata), 128'h83);
        check("t4_drop_cnt", 128'(drop_cnt), 128'd2);
        check("t4_cmd_tvalid", 128'(cmd_tvalid), 128'd0);
        pop_err();
        check("t4_err_popped", 128'(err_tvalid), 128'd0);

        // 5: fill the queue, back-pressure, drain in order, counter wrap
        rst_on(); rst_off();
        cmd_tready = 1'b0;
        for (int i = 0; i < 8; i++) send_cmd(mk(i));
        check("t5_cmd_cnt8", 128'(cmd_cnt), 128'd8);
        check("t5_head", cmd_tdata, mk(0));
        c = mk(8);
        s_tvalid = 1'b1;
        s_tdata  = c[31:0];
        s_tlast  = 1'b0;
        #1;
        check("t5_full_ready", 128'(s_tready), 128'd0);
        @(posedge aclk); #1;
        check("t5_full_ready_hold", 128'(s_tready), 128'd0);
        check("t5_head_stable", cmd_tdata, mk(0));
        cmd_tready = 1'b1;
        send_cmd(c);
        wait_got(9);
        for (int i = 0; i < 9; i++) check($sformatf("t5_order%0d", i), got[i], mk(i));
        check("t5_cmd_cnt9", 128'(cmd_cnt), 128'd9);
        for (int i = 9; i < 16; i++) send_cmd(mk(i));
        wait_got(16);
        check("t5_last", got[15], mk(15));
        check("t5_cnt_wrap", 128'(cmd_cnt), 128'd0);

        // 6: reset mid-command
        rst_on(); rst_off();
        send_beat(32'h00000002, 1'b0);
        send_beat(32'h0000DEAD, 1'b0);
        rst_on();
        check("t6_s_tready", 128'(s_tready), 128'd0);
        check("t6_cmd_tvalid", 128'(cmd_tvalid), 128'd0);
        check("t6_cmd_tdata", cmd_tdata, 128'd0);
        check("t6_err_tvalid", 128'(err_tvalid), 128'd0);
        check("t6_err_tdata", 128'(err_tdata), 128'd0);
        check("t6_cmd_cnt", 128'(cmd_cnt), 128'd0);
        rst_off();
        send_cmd(128'h44444444_33333333_22222222_00000002);
        wait_got(1);
        check("t6_cmd", got[0], 128'h44444444_33333333_22222222_00000002);
        check("t6_drop_cnt", 128'(drop_cnt), 128'd0);
        check("t6_no_err", 128'(err_tvalid), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
